mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read, single-write MIX memory port (4096 x 31 bit) among four requesters: CPU (fetch, operand, ST), MOV engine, IN (serial receive, writes) and OUT (serial transmit, reads).
- Replaces the ad-hoc address/write-enable priority mux in the top level with an explicit request/grant handshake.
- Adds per-port read-valid tagging and a starvation guard so the serial I/O engines cannot be locked out by long CPU or MOV streams.

Parameters:
- AW, 12, address width
- DW, 31, word width (sign + 5 bytes x 6 bits)
- STARVE, 8, cycles an I/O request may wait ungranted before it is promoted above the CPU (legal range 1..255)

Ports:
- clk in 1 system clock
- reset in 1 synchronous, active-high
- cpu_req in 1; cpu_we in 1; cpu_addr in AW; cpu_wdata in DW: CPU access request
- cpu_gnt out 1; cpu_rvalid out 1: grant and read-data-valid
- mov_req in 1; mov_we in 1; mov_addr in AW; mov_wdata in DW: MOV engine access request
- mov_gnt out 1; mov_rvalid out 1: grant and read-data-valid
- in_req in 1; in_addr in AW; in_wdata in DW: IN engine request, write only
- in_gnt out 1: IN grant
- out_req in 1; out_addr in AW: OUT engine request, read only
- out_gnt out 1; out_rvalid out 1: grant and read-data-valid
- mem_addr out AW; mem_we out 1; mem_wdata out DW: memory port drive
- mem_rdata in DW: memory read data, valid one cycle after address
- rdata out DW: shared read data, equal to mem_rdata

Behaviour:
- Grants:
  - Combinational from the current *_req and registered arbitration state.
  - At most one *_gnt high per cycle.
  - The granted port's addr/we/wdata drive mem_*.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Base priority: cpu > mov > io.
- io slot: in and out alternate round-robin via a 1-bit pointer rr.
  - rr=0 favours in; rr=1 favours out.
  - After an io grant, rr points to the other io port.
- Starvation:
  - Per-port 8-bit counters wait_in and wait_out.
  - A counter increments each cycle its req=1 and gnt=0, saturating at 255.
  - It clears on grant, or on req=0.
  - A port whose counter is >= STARVE is "starved" and outranks both cpu and mov.
  - If in and out are both starved, rr decides.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - One transfer per gnt cycle; a requester may re-request back-to-back.
- Write: performed at the clock edge ending the gnt cycle.
- Read latency:
  - The matching *_rvalid pulses exactly 1 cycle after a read grant (we=0), with rdata = mem_rdata.
  - Writes produce no rvalid.
  - rvalid is tagged by a registered 2-bit port id plus a valid bit; never two rvalid in one cycle.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data (memory write-then-read ordering).
- Reset: clears rr=0, wait_in=0, wait_out=0 and all rvalid, with no further conditions.
  - A read granted in the cycle reset is asserted produces no rvalid.
  - During reset cycles gnt still evaluates, but mem_we is forced 0.
- Outputs at reset: all *_gnt follow reqs (combinational), all *_rvalid=0, mem_we=0.
- Illegal input (in_req with write disabled is impossible by construction; out never writes): mem_we for the out port is tied 0.

Test Plan:
- Single CPU read: cpu_req=1, addr=3424, mem holds 31'h12345678 -> cpu_gnt same cycle, cpu_rvalid=1 next cycle, rdata=31'h12345678; no other gnt/rvalid.
- Priority: cpu, mov, in and out all requesting with wait counters 0 -> grant order cpu, cpu while held, then mov when cpu drops, then in, then out (rr alternation).
- Round-robin: in_req and out_req continuously high, cpu/mov idle -> grants alternate in, out, in, out; each write lands at in_addr; out_rvalid follows each out grant by 1 cycle.
- Starvation (STARVE=8): cpu_req held high 20 cycles with out_req high -> out_gnt on cycle 9 (counter reaches 8), wait_out clears, cpu regains grant next cycle.
- Read-after-write: CPU writes 31'h7FFFFFFF to addr 100, MOV reads addr 100 next cycle -> mov_rvalid with rdata=31'h7FFFFFFF.
- Reset mid-read: out read granted in the cycle reset is high -> no out_rvalid; rr=0 and counters 0 after reset; first io grant with both pending goes to in.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing one synchronous MIX memory port among CPU, MOV, IN and OUT.
// Fixed priority cpu > mov > io, round-robin between the io ports, and a starvation guard for io.
module mem_port_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 31,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,

    input  logic          mov_req,
    input  logic          mov_we,
    input  logic [AW-1:0] mov_addr,
    input  logic [DW-1:0] mov_wdata,
    output logic          mov_gnt,
    output logic          mov_rvalid,

    input  logic          in_req,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    output logic          in_gnt,

    input  logic          out_req,
    input  logic [AW-1:0] out_addr,
    output logic          out_gnt,
    output logic          out_rvalid,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata
);

    typedef enum logic [1:0] {
        PORT_CPU = 2'd0,
        PORT_MOV = 2'd1,
        PORT_IN  = 2'd2,
        PORT_OUT = 2'd3
    } port_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE);

    logic       rr;
    logic [7:0] wait_in;
    logic [7:0] wait_out;
    logic       rv_valid;
    port_e      rv_port;

    logic       in_starved;
    logic       out_starved;
    logic       any_gnt;
    logic       read_gnt;
    logic       sel_we;
    port_e      gnt_port;

    // A starved io port only counts while it is still requesting.
    assign in_starved  = in_req  && (wait_in  >= STARVE_LIM);
    assign out_starved = out_req && (wait_out >= STARVE_LIM);

    always_comb begin
        cpu_gnt = 1'b0;
        mov_gnt = 1'b0;
        in_gnt  = 1'b0;
        out_gnt = 1'b0;
        if (in_starved && out_starved) begin
            if (rr) out_gnt = 1'b1;
            else    in_gnt  = 1'b1;
        end else if (in_starved) begin
            in_gnt = 1'b1;
        end else if (out_starved) begin
            out_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (mov_req) begin
            mov_gnt = 1'b1;
        end else if (in_req && (!out_req || !rr)) begin
            in_gnt = 1'b1;
        end else if (out_req) begin
            out_gnt = 1'b1;
        end
    end

    // Route the granted port onto the memory; the out port never writes.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        sel_we    = 1'b0;
        gnt_port  = PORT_CPU;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            sel_we    = cpu_we;
            gnt_port  = PORT_CPU;
        end else if (mov_gnt) begin
            mem_addr  = mov_addr;
            mem_wdata = mov_wdata;
            sel_we    = mov_we;
            gnt_port  = PORT_MOV;
        end else if (in_gnt) begin
            mem_addr  = in_addr;
            mem_wdata = in_wdata;
            sel_we    = 1'b1;
            gnt_port  = PORT_IN;
        end else if (out_gnt) begin
            mem_addr  = out_addr;
            sel_we    = 1'b0;
            gnt_port  = PORT_OUT;
        end
    end

    assign any_gnt  = cpu_gnt | mov_gnt | in_gnt | out_gnt;
    assign read_gnt = any_gnt && !sel_we;
    assign mem_we   = sel_we && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr       <= 1'b0;
            wait_in  <= 8'd0;
            wait_out <= 8'd0;
            rv_valid <= 1'b0;
            rv_port  <= PORT_CPU;
        end else begin
            if (in_gnt)
                rr <= 1'b1;
            else if (out_gnt)
                rr <= 1'b0;

            if (!in_req || in_gnt)
                wait_in <= 8'd0;
            else if (wait_in != 8'hFF)
                wait_in <= wait_in + 8'd1;

            if (!out_req || out_gnt)
                wait_out <= 8'd0;
            else if (wait_out != 8'hFF)
                wait_out <= wait_out + 8'd1;

            rv_valid <= read_gnt;
            rv_port  <= gnt_port;
        end
    end

    assign cpu_rvalid = rv_valid && (rv_port == PORT_CPU);
    assign mov_rvalid = rv_valid && (rv_port == PORT_MOV);
    assign out_rvalid = rv_valid && (rv_port == PORT_OUT);
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// hold-until-grant requesters, compared against a score-based reference model.
module tb_mem_port_arbiter;

    localparam int AW     = 12;
    localparam int DW     = 31;
    localparam int STARVE = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          mov_req, mov_we, mov_gnt, mov_rvalid;
    logic [AW-1:0] mov_addr;
    logic [DW-1:0] mov_wdata;
    logic          in_req, in_gnt;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          out_req, out_gnt, out_rvalid;
    logic [AW-1:0] out_addr;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rdata;

    logic [DW-1:0] env_mem [4096];
    logic [DW-1:0] ref_mem [4096];

    int vectors     = 0;
    int miscompares = 0;

    int            m_rr      = 0;
    int            m_wait_in = 0;
    int            m_wait_out = 0;
    int            m_rd_port = -1;
    logic [DW-1:0] m_rd_data = '0;
    int            last_win  = -1;
    logic [3:0]    obs_gnt;
    bit            pend [4];

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .mov_req(mov_req), .mov_we(mov_we), .mov_addr(mov_addr), .mov_wdata(mov_wdata),
        .mov_gnt(mov_gnt), .mov_rvalid(mov_rvalid),
        .in_req(in_req), .in_addr(in_addr), .in_wdata(in_wdata), .in_gnt(in_gnt),
        .out_req(out_req), .out_addr(out_addr), .out_gnt(out_gnt), .out_rvalid(out_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Winner = highest score among requesters: starved io beats everything, then cpu, mov, io,
    // with the rr-favoured io port getting a one-point edge.
    function automatic int pickWinner();
        int best = -1;
        int best_score = -1;
        int s;
        bit req [4];
        req = '{cpu_req, mov_req, in_req, out_req};
        for (int p = 0; p < 4; p++) begin
            if (req[p]) begin
                case (p)
                    0: s = 50;
                    1: s = 40;
                    2: s = ((m_wait_in  >= STARVE) ? 100 : 0) + ((m_rr == 0) ? 1 : 0);
                    default: s = ((m_wait_out >= STARVE) ? 100 : 0) + ((m_rr == 1) ? 1 : 0);
                endcase
                if (s > best_score) begin
                    best_score = s;
                    best = p;
                end
            end
        end
        return best;
    endfunction

    task automatic checkOutput(input string tag);
        int            win;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [2:0]    e_rv;
        logic          cap_we;
        logic [AW-1:0] cap_addr;
        logic [DW-1:0] cap_wd;
        #1;
        win = pickWinner();
        obs_gnt = {out_gnt, in_gnt, mov_gnt, cpu_gnt};
        cmp({tag, ".gnt"}, 64'(obs_gnt), (win < 0) ? 64'd0 : 64'(4'b0001 << win));
        case (win)
            0:       begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
            1:       begin e_we = mov_we; e_addr = mov_addr; e_wd = mov_wdata; end
            2:       begin e_we = 1'b1;   e_addr = in_addr;  e_wd = in_wdata;  end
            3:       begin e_we = 1'b0;   e_addr = out_addr; e_wd = '0;        end
            default: begin e_we = 1'b0;   e_addr = '0;       e_wd = '0;        end
        endcase
        cmp({tag, ".mem_we"}, 64'(mem_we), 64'(e_we && !reset));
        cmp({tag, ".mem_addr"}, 64'(mem_addr), 64'(e_addr));
        cmp({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wd));
        e_rv = (m_rd_port == 0) ? 3'b001 : (m_rd_port == 1) ? 3'b010 :
               (m_rd_port == 3) ? 3'b100 : 3'b000;
        cmp({tag, ".rvalid"}, 64'({out_rvalid, mov_rvalid, cpu_rvalid}), 64'(e_rv));
        if (m_rd_port >= 0)
            cmp({tag, ".rdata"}, 64'(rdata), 64'(m_rd_data));

        cap_we   = mem_we;
        cap_addr = mem_addr;
        cap_wd   = mem_wdata;
        last_win = win;

        @(posedge clk);
        if (cap_we) env_mem[cap_addr] = cap_wd;
        mem_rdata = env_mem[cap_addr];

        if (!reset && win >= 0 && !e_we) begin
            m_rd_port = win;
            m_rd_data = ref_mem[e_addr];
        end else begin
            m_rd_port = -1;
        end
        if (!reset && e_we) ref_mem[e_addr] = e_wd;
        if (reset) begin
            m_rr = 0; m_wait_in = 0; m_wait_out = 0;
        end else begin
            if (win == 2) m_rr = 1;
            else if (win == 3) m_rr = 0;
            m_wait_in  = (!in_req  || win == 2) ? 0 : ((m_wait_in  < 255) ? m_wait_in  + 1 : 255);
            m_wait_out = (!out_req || win == 3) ? 0 : ((m_wait_out < 255) ? m_wait_out + 1 : 255);
        end
        @(negedge clk);
    endtask

    // Random requesters: each holds its request stable until granted, then may re-request.
    task automatic applyStimulus();
        if (last_win >= 0) pend[last_win] = 1'b0;
        if (!pend[0] && $urandom_range(99) < 70) begin
            pend[0] = 1'b1; cpu_we = 1'($urandom_range(1));
            cpu_addr = AW'($urandom_range(15)); cpu_wdata = DW'($urandom());
        end
        if (!pend[1] && $urandom_range(99) < 50) begin
            pend[1] = 1'b1; mov_we = 1'($urandom_range(1));
            mov_addr = AW'($urandom_range(15)); mov_wdata = DW'($urandom());
        end
        if (!pend[2] && $urandom_range(99) < 30) begin
            pend[2] = 1'b1; in_addr = AW'($urandom_range(15)); in_wdata = DW'($urandom());
        end
        if (!pend[3] && $urandom_range(99) < 30) begin
            pend[3] = 1'b1; out_addr = AW'($urandom_range(15));
        end
        cpu_req = pend[0];
        mov_req = pend[1];
        in_req  = pend[2];
        out_req = pend[3];
        reset   = ($urandom_range(99) == 0);
    endtask

    initial begin
        int got_cycle;
        int win_after;
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] = DW'(i * 7919 + 13);
            ref_mem[i] = DW'(i * 7919 + 13);
        end
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mov_req = 1'b0; mov_we = 1'b0; mov_addr = '0; mov_wdata = '0;
        in_req = 1'b0; in_addr = '0; in_wdata = '0;
        out_req = 1'b0; out_addr = '0;
        mem_rdata = '0;
        @(negedge clk);

        // Reset state
        checkOutput("reset0");
        checkOutput("reset1");
        reset = 1'b0;

        // Single CPU read
        env_mem[3424] = 31'h12345678;
        ref_mem[3424] = 31'h12345678;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd3424;
        checkOutput("cpu_rd");
        cmp("cpu_rd.gnt_const", 64'(obs_gnt), 64'b0001);
        cpu_req = 1'b0;
        cmp("cpu_rd.rvalid_const", 64'({out_rvalid, mov_rvalid, cpu_rvalid}), 64'b001);
        cmp("cpu_rd.rdata_const", 64'(rdata), 64'h12345678);
        checkOutput("cpu_rd_idle");

        // Priority: cpu, cpu, mov, in, out
        cpu_req = 1'b1; cpu_addr = 12'd10;
        mov_req = 1'b1; mov_we = 1'b0; mov_addr = 12'd11;
        in_req = 1'b1; in_addr = 12'd200; in_wdata = 31'h0ABCDEF0;
        out_req = 1'b1; out_addr = 12'd200;
        checkOutput("prio1"); cmp("prio1.order", 64'(obs_gnt), 64'b0001);
        checkOutput("prio2"); cmp("prio2.order", 64'(obs_gnt), 64'b0001);
        cpu_req = 1'b0;
        checkOutput("prio3"); cmp("prio3.order", 64'(obs_gnt), 64'b0010);
        mov_req = 1'b0;
        checkOutput("prio4"); cmp("prio4.order", 64'(obs_gnt), 64'b0100);
        in_req = 1'b0;
        checkOutput("prio5"); cmp("prio5.order", 64'(obs_gnt), 64'b1000);
        out_req = 1'b0;
        checkOutput("prio_idle");

        // Round-robin between in and out
        in_req = 1'b1; out_req = 1'b1; in_addr = 12'd300; in_wdata = 31'h11111111; out_addr = 12'd300;
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr");
            cmp("rr.alternate", 64'(obs_gnt), (k % 2 == 0) ? 64'b0100 : 64'b1000);
            if (k % 2 == 0) begin
                in_addr  = AW'(301 + k);
                in_wdata = DW'($urandom());
            end
        end
        in_req = 1'b0; out_req = 1'b0;
        checkOutput("rr_idle");

        // Starvation: out promoted above a continuous CPU stream
        got_cycle = 0; win_after = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd5;
        out_req = 1'b1; out_addr = 12'd7;
        for (int k = 1; k <= 20; k++) begin
            checkOutput("starve");
            if (got_cycle != 0 && k == got_cycle + 1) win_after = last_win;
            if (got_cycle == 0 && obs_gnt == 4'b1000) begin
                got_cycle = k;
                out_req = 1'b0;
            end
        end
        cmp("starve.cycle", 64'(got_cycle), 64'd9);
        cmp("starve.cpu_back", 64'(win_after), 64'd0);
        cpu_req = 1'b0;
        checkOutput("starve_idle");

        // Read-after-write: CPU write then MOV read of the same address
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd100; cpu_wdata = 31'h7FFFFFFF;
        checkOutput("raw_wr");
        cpu_req = 1'b0; cpu_we = 1'b0;
        mov_req = 1'b1; mov_we = 1'b0; mov_addr = 12'd100;
        checkOutput("raw_rd");
        mov_req = 1'b0;
        cmp("raw.mov_rvalid", 64'(mov_rvalid), 64'd1);
        cmp("raw.rdata", 64'(rdata), 64'h7FFFFFFF);
        checkOutput("raw_idle");

        // Reset mid-read
        in_req = 1'b1; in_addr = 12'd50; in_wdata = 31'h02020202;
        checkOutput("rst_pre");
        in_req = 1'b0;
        reset = 1'b1; out_req = 1'b1; out_addr = 12'd50;
        checkOutput("rst_out");
        cmp("rst_out.gnt", 64'(obs_gnt), 64'b1000);
        out_req = 1'b0;
        cmp("rst_out.no_rvalid", 64'(out_rvalid), 64'd0);
        in_req = 1'b1; in_addr = 12'd60; in_wdata = 31'h03030303;
        checkOutput("rst_in");
        reset = 1'b0; out_req = 1'b1;
        checkOutput("rst_both");
        cmp("rst_both.in_first", 64'(obs_gnt), 64'b0100);
        in_req = 1'b0;
        checkOutput("rst_out2");
        out_req = 1'b0;
        checkOutput("rst_idle");

        // Random phase
        last_win = -1;
        for (int p = 0; p < 4; p++) pend[p] = 1'b0;
        for (int k = 0; k < 600; k++) begin
            applyStimulus();
            checkOutput("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
